// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_unit_pkg : shared fetch-state encoding, NOP word and PC step
// Revision: 1.0
// ============================================================================
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : single-outstanding instruction fetch with decoder output register
// Revision: 1.0
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic         w_pop;
  logic         w_accept;
  logic         w_take_resp;

  assign w_pop       = inst_valid & inst_ready;
  assign w_accept    = imem_req_valid & imem_req_ready;
  assign w_take_resp = (r_state == FETCH_WAIT) & imem_resp_valid & ~redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A redirect racing an in-flight request leaves a stale response to drain.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_REQ: begin
        if (w_accept) begin
          w_state_next = redirect_valid ? FETCH_DRAIN : FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          w_state_next = FETCH_REQ;
        end else if (redirect_valid) begin
          w_state_next = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (imem_resp_valid) begin
          w_state_next = FETCH_REQ;
        end
      end
      default: w_state_next = FETCH_REQ;
    endcase
  end

  // rst_n gates the request so nothing is presented while reset is held.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = r_pc;
    if (r_state == FETCH_REQ) begin
      imem_req_valid = rst_n & (~inst_valid | inst_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= align_pc(RESET_PC);
      inst_valid <= 1'b0;
      inst       <= NOP_INSN;
      inst_pc    <= 32'd0;
    end else if (redirect_valid) begin
      r_pc       <= align_pc(redirect_pc);
      inst_valid <= 1'b0;
    end else if (w_take_resp) begin
      inst       <= imem_resp_data;
      inst_pc    <= r_pc;
      inst_valid <= 1'b1;
      r_pc       <= r_pc + PC_INC;
    end else if (w_pop) begin
      inst_valid <= 1'b0;
    end
  end

  a_no_resp_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && (r_state == FETCH_REQ)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : vector table, directed corner sequences and random traffic
// Revision: 1.0
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] target;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // memory model state
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          resp_cyc  = 0;
  int          mem_lat   = 1;
  logic        mem_rdy   = 1'b1;
  logic        rst_drive = 1'b0;

  // per-cycle observations
  logic        obs_req, obs_acc, obs_pop, obs_iv, obs_resp;
  logic [31:0] obs_addr, obs_inst, obs_ipc;

  // reference instruction stream
  logic [31:0] exp_pc  = RST_PC;
  int          n_deliv = 0;
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_inst_q[$];
  int          acc_cyc_q[$];
  logic [31:0] acc_addr_q[$];

  logic        prev_stall = 1'b0;
  logic        prev_hold  = 1'b0;
  logic [31:0] prev_inst, prev_ipc, prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic dec_rdy);
    @(negedge clk);
    cyc++;
    rst_n           = rst_drive;
    redirect_valid  = rd;
    redirect_pc     = rpc;
    inst_ready      = dec_rdy;
    imem_req_ready  = mem_rdy;
    imem_resp_valid = pend && (cyc == resp_cyc);
    imem_resp_data  = imem_resp_valid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    #1;
    obs_req  = imem_req_valid;
    obs_addr = imem_req_addr;
    obs_iv   = inst_valid;
    obs_inst = inst;
    obs_ipc  = inst_pc;
    obs_acc  = imem_req_valid && imem_req_ready;
    obs_pop  = inst_valid && inst_ready;
    obs_resp = imem_resp_valid;
    if (prev_stall) begin
      chk("hold_valid", {31'd0, obs_iv}, 32'd1);
      chk("hold_inst", obs_inst, prev_inst);
      chk("hold_pc", obs_ipc, prev_ipc);
    end
    if (prev_hold) begin
      chk("req_hold_valid", {31'd0, obs_req}, 32'd1);
      chk("req_hold_addr", obs_addr, prev_addr);
    end
    if (obs_req) chk("req_align", {30'd0, obs_addr[1:0]}, 32'd0);
    if (obs_resp) pend = 1'b0;
    if (obs_acc) begin
      chk("one_outstanding", {31'd0, pend}, 32'd0);
      pend      = 1'b1;
      pend_addr = obs_addr;
      resp_cyc  = cyc + mem_lat;
      acc_cyc_q.push_back(cyc);
      acc_addr_q.push_back(obs_addr);
    end
    if (obs_pop) begin
      chk("stream_pc", obs_ipc, exp_pc);
      chk("stream_inst", obs_inst, mem_word(exp_pc));
      pop_pc_q.push_back(obs_ipc);
      pop_inst_q.push_back(obs_inst);
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (rd) exp_pc = {rpc[31:2], 2'b00};
    prev_stall = obs_iv && !dec_rdy && !rd;
    prev_hold  = obs_req && !mem_rdy && !rd;
    prev_inst  = obs_inst;
    prev_ipc   = obs_ipc;
    prev_addr  = obs_addr;
  endtask

  vec_t        tbl[5];
  logic [31:0] exp_j;
  logic        rd;
  logic        last_rd;
  logic [31:0] rpc;
  int          base;

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;

    tbl[0] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
    tbl[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
    tbl[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    tbl[4] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008};

    // reset values
    repeat (3) cycle(1'b0, 32'd0, 1'b1);
    chk("rst_inst_valid", {31'd0, obs_iv}, 32'd0);
    chk("rst_inst", obs_inst, 32'h0000_0013);
    chk("rst_inst_pc", obs_ipc, 32'd0);
    chk("rst_req_valid", {31'd0, obs_req}, 32'd0);

    // back-to-back fetch from RESET_PC with 1-cycle memory
    mem_rdy = 1'b1; mem_lat = 1; rst_drive = 1'b1;
    acc_cyc_q.delete(); acc_addr_q.delete(); pop_pc_q.delete(); pop_inst_q.delete();
    cycle(1'b0, 32'd0, 1'b1);
    chk("first_req_valid", {31'd0, obs_acc}, 32'd1);
    chk("first_req_addr", obs_addr, RST_PC);
    repeat (5) cycle(1'b0, 32'd0, 1'b1);
    chk("seq_n_acc", acc_cyc_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < acc_cyc_q.size(); i++) begin
      chk("seq_addr", acc_addr_q[i], RST_PC + 32'(4 * i));
      if (i > 0) chk("seq_gap", acc_cyc_q[i] - acc_cyc_q[i-1], 32'd2);
    end
    chk("seq_n_pop", pop_pc_q.size(), 32'd2);
    for (int i = 0; i < pop_pc_q.size(); i++) chk("seq_inst_pc", pop_pc_q[i], RST_PC + 32'(4 * i));

    // decoder stall holds the output register and blocks requests
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'd0, 1'b0);
      chk("stall_valid", {31'd0, obs_iv}, 32'd1);
      chk("stall_noreq", {31'd0, obs_req}, 32'd0);
      chk("stall_inst", obs_inst, mem_word(RST_PC + 32'd8));
      chk("stall_ipc", obs_ipc, RST_PC + 32'd8);
    end
    mem_lat = 4;
    cycle(1'b0, 32'd0, 1'b1);
    chk("pop_req", {31'd0, obs_acc}, 32'd1);
    chk("pop_addr", obs_addr, RST_PC + 32'd12);

    // redirect while waiting; late response is dropped
    cycle(1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'd0, 1'b1);
      chk("drain_iv", {31'd0, obs_iv}, 32'd0);
      chk("drain_noreq", {31'd0, obs_req}, 32'd0);
    end
    chk("drain_resp_seen", {31'd0, obs_resp}, 32'd1);
    mem_lat = 2;
    cycle(1'b0, 32'd0, 1'b1);
    chk("after_drain_req", {31'd0, obs_acc}, 32'd1);
    chk("after_drain_addr", obs_addr, 32'h0000_0200);
    chk("after_drain_iv", {31'd0, obs_iv}, 32'd0);

    // redirect coincident with response: no drain
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b1, 32'h0000_0203, 1'b1);
    chk("coinc_resp_seen", {31'd0, obs_resp}, 32'd1);
    mem_lat = 1;
    cycle(1'b0, 32'd0, 1'b1);
    chk("coinc_req", {31'd0, obs_acc}, 32'd1);
    chk("coinc_addr", obs_addr, 32'h0000_0200);
    chk("coinc_iv", {31'd0, obs_iv}, 32'd0);

    // vector table: redirect target -> first three delivered PCs
    for (int t = 0; t < 5; t++) begin
      cycle(1'b1, tbl[t].target, 1'b1);
      pop_pc_q.delete(); pop_inst_q.delete();
      for (int k = 0; k < 40 && pop_pc_q.size() < 3; k++) cycle(1'b0, 32'd0, 1'b1);
      chk("tbl_count", pop_pc_q.size(), 32'd3);
      for (int j = 0; j < 3 && j < pop_pc_q.size(); j++) begin
        exp_j = (j == 0) ? tbl[t].e0 : ((j == 1) ? tbl[t].e1 : tbl[t].e2);
        chk("tbl_pc", pop_pc_q[j], exp_j);
        chk("tbl_inst", pop_inst_q[j], mem_word(exp_j));
      end
    end

    // asynchronous reset while a request is outstanding
    mem_lat = 3;
    obs_acc = 1'b0;
    for (int k = 0; k < 20 && !obs_acc; k++) cycle(1'b0, 32'd0, 1'b1);
    chk("pre_reset_acc", {31'd0, obs_acc}, 32'd1);
    #6;
    rst_drive = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("async_rst_iv", {31'd0, inst_valid}, 32'd0);
    chk("async_rst_req", {31'd0, imem_req_valid}, 32'd0);
    chk("async_rst_inst", inst, 32'h0000_0013);
    chk("async_rst_ipc", inst_pc, 32'd0);
    pend = 1'b0; exp_pc = RST_PC; prev_stall = 1'b0; prev_hold = 1'b0;
    repeat (2) begin
      cycle(1'b0, 32'd0, 1'b1);
      chk("in_rst_noreq", {31'd0, obs_req}, 32'd0);
    end
    rst_drive = 1'b1;
    cycle(1'b0, 32'd0, 1'b1);
    chk("post_rst_req", {31'd0, obs_acc}, 32'd1);
    chk("post_rst_addr", obs_addr, RST_PC);

    // random traffic against the reference stream
    base    = n_deliv;
    last_rd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      mem_rdy = ($urandom_range(0, 9) < 7);
      mem_lat = $urandom_range(1, 4);
      rd      = !last_rd && ($urandom_range(0, 99) < 3);
      rpc     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
      cycle(rd, rpc, $urandom_range(0, 3) != 0);
      last_rd = rd;
    end
    chk("progress", (n_deliv - base > 200) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1  fetch request present.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_req_addr  output  32  fetch address; bits [1:0] always 0.
REQ-007 imem_resp_valid  input  1  instruction word returned; exactly one per accepted request, at least 1 cycle after acceptance.
REQ-008 imem_resp_data  input  32  returned instruction word.
REQ-009 redirect_valid  input  1  branch/jump/trap redirect, single-cycle pulse.
REQ-010 redirect_pc  input  32  new fetch PC; bits [1:0] ignored, treated as 0.
REQ-011 inst_valid  output  1  output register holds an instruction for the decoder.
REQ-012 inst_ready  input  1  decoder consumes instruction.
REQ-013 inst  output  32  instruction word to decoder.
REQ-014 inst_pc  output  32  address of inst.

Function
REQ-015 The block SHALL keep at most one outstanding memory request.
REQ-016 FSM states SHALL be REQ (may issue), WAIT (response pending), DRAIN (discard stale response).
REQ-017 In REQ, imem_req_valid SHALL be 1 only when the output register is empty or popped this cycle (inst_valid & inst_ready); imem_req_addr = pc.
REQ-018 imem_req_addr SHALL hold stable while imem_req_valid & !imem_req_ready, unless a redirect occurs.
REQ-019 Request accepted (valid & ready) in REQ: next state WAIT.
REQ-020 imem_resp_valid in WAIT with no redirect: inst <= imem_resp_data, inst_pc <= pc, inst_valid <= 1, pc <= pc + 4, next state REQ.
REQ-021 Latency: response in cycle N SHALL give inst_valid = 1 in cycle N+1; next request may issue in cycle N+1 if the decoder pops in N+1.
REQ-022 pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 inst and inst_pc SHALL stay stable while inst_valid & !inst_ready.
REQ-024 redirect_valid SHALL have top priority: pc <= {redirect_pc[31:2],2'b00}, inst_valid <= 0 in the same edge.
REQ-025 Redirect in REQ with no accepted request: stay REQ; new address from next cycle.
REQ-026 Redirect in REQ coincident with request acceptance: next state DRAIN.
REQ-027 Redirect in WAIT without response: next state DRAIN.
REQ-028 Redirect in WAIT coincident with imem_resp_valid: response discarded, next state REQ.
REQ-029 In DRAIN, imem_req_valid SHALL be 0; imem_resp_valid discards data and moves to REQ; a further redirect only updates pc.
REQ-030 imem_resp_valid in REQ SHALL be ignored (protocol violation, flagged by assertion).

Reset
REQ-031 On rst_n low, asynchronously: state REQ, pc = RESET_PC, inst_valid = 0, inst = NOP (32'h0000_0013), inst_pc = 0, imem_req_valid = 0.
REQ-032 First request SHALL be issued in the first cycle after rst_n deasserts, address RESET_PC.
REQ-033 Reset mid-WAIT SHALL drop the outstanding request; memory is reset on the same rst_n.

Structure
REQ-034 The fetch FSM state enum, NOP encoding and PC increment constant (4) SHALL reside in the shared constants package.
REQ-035 Single module, no sub-modules; the output register SHALL feed instruction_decoder inst directly.

Verification
REQ-036 Reset with RESET_PC=32'h100, imem_req_ready=1, 1-cycle memory, inst_ready=1 -> addresses 0x100,0x104,0x108 issued; inst_pc matches, one instruction every 2 cycles.
REQ-037 inst_ready=0 for 5 cycles while inst_valid=1 -> inst/inst_pc stable, imem_req_valid=0; pop -> request issued in same cycle.
REQ-038 Redirect to 32'h200 in WAIT, response 3 cycles later -> response dropped, inst_valid stays 0, next request address 0x200.
REQ-039 Redirect to 32'h203 coincident with response -> response discarded, next request 0x200, no DRAIN.
REQ-040 pc = 32'hFFFF_FFFC fetched -> next request address 32'h0000_0000.
REQ-041 rst_n asserted mid-WAIT -> outputs at reset values immediately, first post-reset request at RESET_PC.
